// File: rtl/uart_txrx.sv
// rtl/uart_txrx.sv - 8N1 UART, independent TX and RX paths; define UART_RX_FRAME_CHECK_EN for o_RX_Frame_Err
`timescale 1ns/1ps
module uart_txrx #(
   parameter int FPGA_clk_freq = 50000000,
   parameter int baudrate      = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_TX_DV,
   input  logic [7:0] i_TX_Byte,
   output logic       o_TX_Active,
   output logic       o_TX_Serial,
   output logic       o_TX_Done,
   input  logic       i_RX_Serial,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte
`ifdef UART_RX_FRAME_CHECK_EN
   ,
   output logic       o_RX_Frame_Err
`endif
);

   localparam int CLKS_PER_BIT = FPGA_clk_freq / baudrate;
   localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_CLEANUP
   } state_t;

   // ---------------- transmit path ----------------
   state_t          tx_state, tx_next;
   logic [CW-1:0]   tx_cnt;
   logic [2:0]      tx_idx;
   logic [7:0]      tx_data;
   logic            tx_bit_end;

   assign tx_bit_end = (tx_cnt == LAST);

   // TX state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tx_state <= S_IDLE;
      else      tx_state <= tx_next;
   end

   // TX bit timer, bit index and byte latch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_cnt  <= '0;
         tx_idx  <= '0;
         tx_data <= '0;
      end else begin
         case (tx_state)
            S_IDLE: begin
               tx_cnt <= '0;
               tx_idx <= '0;
               if (i_TX_DV) tx_data <= i_TX_Byte;
            end
            S_START, S_DATA, S_STOP: begin
               tx_cnt <= tx_bit_end ? '0 : tx_cnt + CW'(1);
               if (tx_state == S_DATA && tx_bit_end) tx_idx <= tx_idx + 3'd1;
            end
            default: begin
               tx_cnt <= '0;
               tx_idx <= '0;
            end
         endcase
      end
   end

   // TX next-state: a new request is only accepted in IDLE
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         S_IDLE:    if (i_TX_DV) tx_next = S_START;
         S_START:   if (tx_bit_end) tx_next = S_DATA;
         S_DATA:    if (tx_bit_end && tx_idx == 3'd7) tx_next = S_STOP;
         S_STOP:    if (tx_bit_end) tx_next = S_CLEANUP;
         S_CLEANUP: tx_next = S_IDLE;
         default:   tx_next = S_IDLE;
      endcase
   end

   // TX outputs decoded from state: line idles high, Done is the single CLEANUP cycle
   always_comb begin
      o_TX_Serial = 1'b1;
      o_TX_Active = 1'b0;
      o_TX_Done   = 1'b0;
      case (tx_state)
         S_START: begin
            o_TX_Serial = 1'b0;
            o_TX_Active = 1'b1;
         end
         S_DATA: begin
            o_TX_Serial = tx_data[tx_idx];
            o_TX_Active = 1'b1;
         end
         S_STOP:    o_TX_Active = 1'b1;
         S_CLEANUP: o_TX_Done   = 1'b1;
         default:   ;
      endcase
   end

   // ---------------- receive path ----------------
   state_t          rx_state, rx_next;
   logic [CW-1:0]   rx_cnt;
   logic [2:0]      rx_idx;
   logic [7:0]      rx_shift;
   logic [7:0]      rx_byte_q;
   logic            rx_dv_q;
   logic            rx_meta, rx_sync;
   logic            rx_bit_end;
   logic            rx_stop_end;
   logic            rx_stop_ok;

   assign rx_bit_end  = (rx_cnt == LAST);
   assign rx_stop_end = (rx_state == S_STOP) && rx_bit_end;

`ifdef UART_RX_FRAME_CHECK_EN
   logic rx_frame_err_q;

   assign rx_stop_ok     = rx_sync;
   assign o_RX_Frame_Err = rx_frame_err_q;

   // one-cycle error strobe when the mid-stop sample is low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_frame_err_q <= 1'b0;
      else      rx_frame_err_q <= rx_stop_end && !rx_sync;
   end
`else
   assign rx_stop_ok = 1'b1;
`endif

   // two-flop synchroniser, reset to the idle-high line level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_RX_Serial;
         rx_sync <= rx_meta;
      end
   end

   // RX state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_state <= S_IDLE;
      else      rx_state <= rx_next;
   end

   // RX bit timer, mid-bit sampling and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_cnt    <= '0;
         rx_idx    <= '0;
         rx_shift  <= '0;
         rx_byte_q <= '0;
         rx_dv_q   <= 1'b0;
      end else begin
         rx_dv_q <= rx_stop_end && rx_stop_ok;
         case (rx_state)
            S_START: rx_cnt <= (rx_cnt == HALF) ? '0 : rx_cnt + CW'(1);
            S_DATA: begin
               if (rx_bit_end) begin
                  rx_cnt           <= '0;
                  rx_shift[rx_idx] <= rx_sync;
                  rx_idx           <= rx_idx + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            S_STOP: begin
               rx_cnt <= rx_bit_end ? '0 : rx_cnt + CW'(1);
               if (rx_bit_end && rx_stop_ok) rx_byte_q <= rx_shift;
            end
            default: begin
               rx_cnt <= '0;
               rx_idx <= '0;
            end
         endcase
      end
   end

   // RX next-state: start bit must still be low at its midpoint
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE:    if (!rx_sync) rx_next = S_START;
         S_START:   if (rx_cnt == HALF) rx_next = rx_sync ? S_IDLE : S_DATA;
         S_DATA:    if (rx_bit_end && rx_idx == 3'd7) rx_next = S_STOP;
         S_STOP:    if (rx_bit_end) rx_next = S_CLEANUP;
         S_CLEANUP: rx_next = S_IDLE;
         default:   rx_next = S_IDLE;
      endcase
   end

   // RX outputs come straight from registers so they are glitch-free
   always_comb begin
      o_RX_DV   = rx_dv_q;
      o_RX_Byte = rx_byte_q;
   end

endmodule

// File: tb/tb_uart_txrx.sv
// tb/tb_uart_txrx.sv - scoreboard bench for uart_txrx
`timescale 1ns/1ps
module tb_uart_txrx;

   localparam int CPB = 50000000 / 115200;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       i_TX_DV = 1'b0;
   logic [7:0] i_TX_Byte = 8'h00;
   logic       o_TX_Active;
   logic       o_TX_Serial;
   logic       o_TX_Done;
   logic       i_RX_Serial;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
`ifdef UART_RX_FRAME_CHECK_EN
   logic       o_RX_Frame_Err;
`endif

   logic loop_en  = 1'b1;
   logic rx_drive = 1'b1;

   assign i_RX_Serial = loop_en ? (o_TX_Active ? o_TX_Serial : 1'b1) : rx_drive;

   uart_txrx dut (
      .clk            (clk),
      .rst            (rst),
      .i_TX_DV        (i_TX_DV),
      .i_TX_Byte      (i_TX_Byte),
      .o_TX_Active    (o_TX_Active),
      .o_TX_Serial    (o_TX_Serial),
      .o_TX_Done      (o_TX_Done),
      .i_RX_Serial    (i_RX_Serial),
      .o_RX_DV        (o_RX_DV),
      .o_RX_Byte      (o_RX_Byte)
`ifdef UART_RX_FRAME_CHECK_EN
      ,
      .o_RX_Frame_Err (o_RX_Frame_Err)
`endif
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] tx_exp_q[$];
   logic [7:0] rx_exp_q[$];
   int dv_cnt = 0;
   int done_cnt = 0;
   int fe_cnt = 0;
   int act_cnt = 0;
   int tx_k;
   logic [7:0] tx_bits;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // RX scoreboard and pulse counters
   always @(negedge clk) begin
      if (rst) begin
         if (o_TX_Done) done_cnt++;
`ifdef UART_RX_FRAME_CHECK_EN
         if (o_RX_Frame_Err) fe_cnt++;
`endif
         if (o_RX_DV) begin
            dv_cnt++;
            if (rx_exp_q.size() == 0) check("rx_spurious_dv", rx_exp_q.size(), 1);
            else check("rx_byte", 32'(o_RX_Byte), 32'(rx_exp_q.pop_front()));
         end
      end
   end

   // independent TX line decoder: samples each bit at its midpoint
   always @(negedge clk) begin
      if (!rst) begin
         act_cnt = 0;
      end else if (o_TX_Active) begin
         if (act_cnt % CPB == CPB / 2) begin
            tx_k = act_cnt / CPB;
            if (tx_k == 0) check("tx_start_bit", 32'(o_TX_Serial), 0);
            else if (tx_k <= 8) tx_bits[tx_k-1] = o_TX_Serial;
            else check("tx_stop_bit", 32'(o_TX_Serial), 1);
         end
         act_cnt++;
      end else if (act_cnt != 0) begin
         check("tx_frame_len", act_cnt, 10 * CPB);
         if (tx_exp_q.size() == 0) check("tx_spurious_frame", tx_exp_q.size(), 1);
         else check("tx_byte", 32'(tx_bits), 32'(tx_exp_q.pop_front()));
         act_cnt = 0;
      end
   end

   task automatic send(input logic [7:0] b, input bit expected);
      @(posedge clk); #1;
      i_TX_DV   = 1'b1;
      i_TX_Byte = b;
      if (expected) begin
         tx_exp_q.push_back(b);
         rx_exp_q.push_back(b);
      end
      @(posedge clk); #1;
      i_TX_DV = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 12 * CPB) begin
         @(negedge clk);
         if (o_TX_Done) seen = 1'b1;
         n++;
      end
      if (!seen) check(tag, 32'(seen), 1);
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
      loop_en = 1'b0;
      @(posedge clk); #1;
      rx_drive = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx_drive = b[i];
         repeat (CPB) @(posedge clk);
      end
      #1 rx_drive = stop_bit;
      repeat (CPB) @(posedge clk);
      #1 rx_drive = 1'b1;
      repeat (2 * CPB) @(posedge clk);
   endtask

   initial begin
      #1_800_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int dv0, done0, fe0;

      // reset values
      repeat (5) @(posedge clk);
      #1;
      check("rst_tx_serial", 32'(o_TX_Serial), 1);
      check("rst_tx_active", 32'(o_TX_Active), 0);
      check("rst_tx_done",   32'(o_TX_Done), 0);
      check("rst_rx_dv",     32'(o_RX_DV), 0);
      check("rst_rx_byte",   32'(o_RX_Byte), 32'h00);
      @(posedge clk); #3 rst = 1'b1;
      repeat (5) @(posedge clk);

      // single loopback frame
      dv0 = dv_cnt; done0 = done_cnt;
      send(8'h37, 1'b1);
      wait_done("loop_timeout");
      repeat (5) @(posedge clk);
      check("loop_dv_count",   dv_cnt - dv0, 1);
      check("loop_done_count", done_cnt - done0, 1);
      check("loop_rx_byte",    32'(o_RX_Byte), 32'h37);

      // back-to-back frames
      dv0 = dv_cnt; done0 = done_cnt;
      send(8'h00, 1'b1); wait_done("b2b0_timeout");
      send(8'hFF, 1'b1); wait_done("b2b1_timeout");
      send(8'hA5, 1'b1); wait_done("b2b2_timeout");
      repeat (5) @(posedge clk);
      check("b2b_dv_count",   dv_cnt - dv0, 3);
      check("b2b_done_count", done_cnt - done0, 3);
      check("b2b_rx_byte",    32'(o_RX_Byte), 32'hA5);

      // short low pulse on the RX line is rejected
      dv0 = dv_cnt;
      loop_en = 1'b0;
      @(posedge clk); #1 rx_drive = 1'b0;
      repeat (100) @(posedge clk);
      #1 rx_drive = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      check("glitch_dv_count", dv_cnt - dv0, 0);
      check("glitch_rx_byte",  32'(o_RX_Byte), 32'hA5);
      loop_en = 1'b1;

      // request while busy is ignored
      dv0 = dv_cnt; done0 = done_cnt;
      send(8'h37, 1'b1);
      repeat (1000) @(posedge clk);
      send(8'h55, 1'b0);
      wait_done("busy_timeout");
      repeat (3 * CPB) @(posedge clk);
      check("busy_dv_count",   dv_cnt - dv0, 1);
      check("busy_done_count", done_cnt - done0, 1);
      check("busy_rx_byte",    32'(o_RX_Byte), 32'h37);
      check("busy_tx_active",  32'(o_TX_Active), 0);

      // reset in the middle of DATA on both paths
      send(8'hC3, 1'b1);
      repeat (3 * CPB) @(posedge clk);
      #3 rst = 1'b0;
      tx_exp_q.delete();
      rx_exp_q.delete();
      #1;
      check("mid_rst_tx_serial", 32'(o_TX_Serial), 1);
      check("mid_rst_tx_active", 32'(o_TX_Active), 0);
      check("mid_rst_tx_done",   32'(o_TX_Done), 0);
      check("mid_rst_rx_dv",     32'(o_RX_DV), 0);
      check("mid_rst_rx_byte",   32'(o_RX_Byte), 32'h00);
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      dv0 = dv_cnt; done0 = done_cnt;
      repeat (2 * CPB) @(posedge clk);
      check("mid_rst_no_dv",   dv_cnt - dv0, 0);
      check("mid_rst_no_done", done_cnt - done0, 0);
      send(8'h5A, 1'b1);
      wait_done("post_rst_timeout");
      repeat (5) @(posedge clk);
      check("post_rst_dv_count", dv_cnt - dv0, 1);
      check("post_rst_rx_byte",  32'(o_RX_Byte), 32'h5A);

      // externally driven frame with a low stop bit
      dv0 = dv_cnt; fe0 = fe_cnt;
`ifdef UART_RX_FRAME_CHECK_EN
      drive_frame(8'h96, 1'b0);
      check("ferr_dv_count",    dv_cnt - dv0, 0);
      check("ferr_pulse_count", fe_cnt - fe0, 1);
      check("ferr_rx_byte",     32'(o_RX_Byte), 32'h5A);
`else
      rx_exp_q.push_back(8'h96);
      drive_frame(8'h96, 1'b0);
      check("ferr_dv_count", dv_cnt - dv0, 1);
      check("ferr_no_err",   fe_cnt - fe0, 0);
      check("ferr_rx_byte",  32'(o_RX_Byte), 32'h96);
`endif

      // externally driven clean frame
      dv0 = dv_cnt; fe0 = fe_cnt;
      rx_exp_q.push_back(8'h81);
      drive_frame(8'h81, 1'b1);
      check("ext_dv_count", dv_cnt - dv0, 1);
      check("ext_no_err",   fe_cnt - fe0, 0);
      check("ext_rx_byte",  32'(o_RX_Byte), 32'h81);
      loop_en = 1'b1;

      repeat (5) @(posedge clk);
      check("rx_queue_empty", rx_exp_q.size(), 0);
      check("tx_queue_empty", tx_exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
